cmd_issue_queue: RTL and testbench

- Upstream stage of the controller: buffers 12-bit commands from the host and issues them in order, one per cycle, on a valid/ready handshake.
- Keeps a scoreboard of the 8 memory addresses with writes in flight.
- Holds the head command on a RAW or WAW hazard until the controller/ALU path reports write-back of that address.

---
 rtl/cmd_issue_queue.sv | 94 +++++++++
 tb/tb_cmd_issue_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// In-order command issue queue with a write-in-flight scoreboard.
// The head command is held while any address it reads or writes still has a write in flight.
module cmd_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CW-1:0]                  in_cmd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CW-1:0]                  out_cmd,
    input  logic                           wb_valid,
    input  logic [2:0]                     wb_addr,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           stall
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready and out_valid depend only on registered state, never on the peer's inputs.

    logic [CW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [7:0]      sb_q, sb_d;

    logic          empty, full, push, pop, hazard;
    logic          is_nop, reads_b;
    logic [CW-1:0] head_cmd;
    logic [2:0]    op, a1, a2, a3;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNTW'(DEPTH));
    assign head_cmd = mem_q[head_q];
    assign op       = head_cmd[11:9];
    assign a1       = head_cmd[8:6];
    assign a2       = head_cmd[5:3];
    assign a3       = head_cmd[2:0];

    // Ops 101..111 are NOPs; NOT (100) reads only addr1.
    assign is_nop  = op[2] & (op[1] | op[0]);
    assign reads_b = ~op[2];

    always_comb begin
        hazard = 1'b0;
        if (!is_nop) begin
            hazard = sb_q[a1] | (reads_b & sb_q[a2]) | sb_q[a3];
        end
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty & ~hazard;
    assign stall     = ~empty & hazard;
    assign out_cmd   = empty ? '0 : head_cmd;
    assign count     = count_q;

    assign push = in_valid & ~full;
    assign pop  = out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        sb_d    = sb_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        if (push && !pop)      count_d = count_q + CNTW'(1);
        else if (pop && !push) count_d = count_q - CNTW'(1);
        // Clear first so an issue setting the same bit in this cycle wins.
        if (wb_valid)          sb_d[wb_addr] = 1'b0;
        if (pop && !is_nop)    sb_d[a3]      = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sb_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sb_q    <= sb_d;
            if (push) mem_q[tail_q] <= in_cmd;
        end
    end
endmodule

// File: tb/tb_cmd_issue_queue.sv
// Directed bench for cmd_issue_queue: reset, issue latency, RAW/WAW hazards,
// full/empty boundaries, pointer wrap and asynchronous mid-run reset.
module tb_cmd_issue_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_cmd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_cmd;
    logic          wb_valid = 1'b0;
    logic [2:0]    wb_addr = '0;
    logic [3:0]    count;
    logic          stall;

    int compared   = 0;
    int mismatched = 0;

    cmd_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .count(count), .stall(stall)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_cmd = 12'hE01;
        #1;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL reset_count got %0d exp 0", count); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %b exp 0", stall); end
        compared++; if (out_cmd !== 12'h000) begin mismatched++; $display("FAIL reset_out_cmd got %h exp 000", out_cmd); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        step();
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL reset_push_ignored count got %0d exp 0", count); end
        in_valid = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_issue();
        do_reset();
        in_valid = 1'b1; in_cmd = 12'h0D1;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_no_bypass out_valid got %b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_latency out_valid got %b exp 1", out_valid); end
        compared++; if (out_cmd !== 12'h0D1) begin mismatched++; $display("FAIL basic_out_cmd got %h exp 0D1", out_cmd); end
        compared++; if (count !== 4'd1) begin mismatched++; $display("FAIL basic_count1 got %0d exp 1", count); end
        out_ready = 1'b1;
        step();
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL basic_count0 got %0d exp 0", count); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_empty_valid got %b exp 0", out_valid); end
        compared++; if (out_cmd !== 12'h000) begin mismatched++; $display("FAIL basic_empty_cmd got %h exp 000", out_cmd); end
        // Bit 1 now pending: SUB reading addr1=1 must stall (RAW).
        in_valid = 1'b1; in_cmd = 12'h24A;
        step();
        in_valid = 1'b0;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL raw_stall got %b exp 1", stall); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL raw_out_valid got %b exp 0", out_valid); end
        compared++; if (out_cmd !== 12'h24A) begin mismatched++; $display("FAIL raw_out_cmd got %h exp 24A", out_cmd); end
        step();
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL raw_stall_hold got %b exp 1", stall); end
        wb_valid = 1'b1; wb_addr = 3'd1;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL raw_wb_same_cycle out_valid got %b exp 0", out_valid); end
        step();
        wb_valid = 1'b0;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL raw_release out_valid got %b exp 1", out_valid); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL raw_release stall got %b exp 0", stall); end
        step();
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL raw_drain count got %0d exp 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_waw();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_cmd = 12'h005;
        step();
        in_cmd = 12'h485;
        step();
        in_valid = 1'b0;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL waw_stall got %b exp 1", stall); end
        compared++; if (out_cmd !== 12'h485) begin mismatched++; $display("FAIL waw_out_cmd got %h exp 485", out_cmd); end
        wb_valid = 1'b1; wb_addr = 3'd4;
        step();
        wb_valid = 1'b0;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL waw_wrong_wb stall got %b exp 1", stall); end
        wb_valid = 1'b1; wb_addr = 3'd5;
        step();
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL waw_release out_valid got %b exp 1", out_valid); end
        // Issue of dest 5 coincides with wb of 5: bit must stay set.
        wb_valid = 1'b1; wb_addr = 3'd5;
        step();
        wb_valid = 1'b0;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL waw_issue count got %0d exp 0", count); end
        in_valid = 1'b1; in_cmd = 12'h805;
        step();
        in_valid = 1'b0;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL set_wins stall got %b exp 1", stall); end
        wb_valid = 1'b1; wb_addr = 3'd5;
        step();
        wb_valid = 1'b0;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL set_wins_release out_valid got %b exp 1", out_valid); end
        step();
        out_ready = 1'b0;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL waw_drain count got %0d exp 0", count); end
    endtask

    task automatic test_fill_drain();
        logic [CW-1:0] exp_cmd;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_cmd = 12'hE00 + CW'(i);
            step();
        end
        compared++; if (count !== 4'd8) begin mismatched++; $display("FAIL full_count got %0d exp 8", count); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_cmd = 12'hE0F;
        step();
        compared++; if (count !== 4'd8) begin mismatched++; $display("FAIL full_push_ignored count got %0d exp 8", count); end
        compared++; if (out_cmd !== 12'hE00) begin mismatched++; $display("FAIL full_head got %h exp E00", out_cmd); end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        compared++; if (count !== 4'd7) begin mismatched++; $display("FAIL full_no_bypass count got %0d exp 7", count); end
        for (int i = 1; i < DEPTH; i++) begin
            exp_cmd = 12'hE00 + CW'(i);
            compared++; if (out_cmd !== exp_cmd || out_valid !== 1'b1 || stall !== 1'b0) begin
                mismatched++; $display("FAIL drain_%0d got cmd=%h v=%b s=%b exp cmd=%h v=1 s=0", i, out_cmd, out_valid, stall, exp_cmd);
            end
            step();
        end
        out_ready = 1'b0;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] exp_q[$];
        logic [CW-1:0] exp_cmd;
        int sent = 0;
        int received = 0;
        int cycles = 0;
        do_reset();
        while (received < 20 && cycles < 500) begin
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            in_cmd    = {3'(3'd5 + 3'(sent % 3)), 9'(sent * 23 + 1)};
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL wrap_unexpected got %h exp none", out_cmd);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    compared++; if (out_cmd !== exp_cmd) begin mismatched++; $display("FAIL wrap_order_%0d got %h exp %h", received, out_cmd, exp_cmd); end
                end
                received++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_cmd);
                sent++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        compared++; if (received !== 20) begin mismatched++; $display("FAIL wrap_received got %0d exp 20", received); end
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL wrap_count got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_cmd = 12'h004;
        step();
        in_cmd = 12'h005;
        step();
        in_cmd = 12'h125;
        step();
        out_ready = 1'b0;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL mid_pre_stall got %b exp 1", stall); end
        for (int i = 0; i < 4; i++) begin
            in_cmd = 12'hE20 + CW'(i);
            step();
        end
        in_valid = 1'b0;
        compared++; if (count !== 4'd5) begin mismatched++; $display("FAIL mid_pre_count got %0d exp 5", count); end
        #1;
        reset = 1'b1;
        #1;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL mid_async_count got %0d exp 0", count); end
        compared++; if (out_valid !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("FAIL mid_async_flags got v=%b s=%b exp v=0 s=0", out_valid, stall); end
        compared++; if (out_cmd !== 12'h000) begin mismatched++; $display("FAIL mid_async_cmd got %h exp 000", out_cmd); end
        step();
        reset = 1'b0;
        step();
        in_valid = 1'b1; in_cmd = 12'h125;
        step();
        in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1 || stall !== 1'b0) begin mismatched++; $display("FAIL mid_after_sb_clear got v=%b s=%b exp v=1 s=0", out_valid, stall); end
        compared++; if (out_cmd !== 12'h125) begin mismatched++; $display("FAIL mid_after_cmd got %h exp 125", out_cmd); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL mid_after_pop count got %0d exp 0", count); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_waw();
        test_fill_drain();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
